serial_out_prog: RTL and testbench

- Programmable successor to the fixed-rate serial output block.
- Shifts out a DATA_BIT-wide pattern one bit at a time; each bit is held for a run-time programmable low or high period, selected per bit by a frequency pattern.
- Adds bit order select, programmable idle level, repeat-N and continuous modes, a gapless frame-to-frame transition and a busy flag.
- Sits between the register/control interface and the pattern output pin.

---
 rtl/serial_out_prog.sv | 166 ++++++++++++++++
 tb/tb_serial_out_prog.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_out_prog.sv
// Programmable serial pattern shifter: per-bit period select, bit order, idle level,
// one-shot / repeat-N / continuous framing with gapless frame-to-frame transitions.
module serial_out_prog #(
    parameter int DATA_BIT = 32,
    parameter int CNT_BIT  = 8,
    parameter int REP_BIT  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [1:0]          i_mode,
    input  logic [REP_BIT-1:0]  i_repeat,
    input  logic                i_msb_first,
    input  logic                i_idle_level,
    input  logic [DATA_BIT-1:0] i_output_pattern,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    input  logic [CNT_BIT-1:0]  i_low_period,
    input  logic [CNT_BIT-1:0]  i_high_period,
    output logic                o_serial_out,
    output logic                o_busy,
    output logic                o_bit_tick,
    output logic                o_done_tick,
    output logic                o_all_done_tick
);

    localparam int IDX_W = $clog2(DATA_BIT);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t state, state_next;

    logic [DATA_BIT-1:0] data_buf;
    logic [DATA_BIT-1:0] freq_buf;
    logic [CNT_BIT-1:0]  low_buf;
    logic [CNT_BIT-1:0]  high_buf;
    logic [1:0]          mode_buf;
    logic [REP_BIT-1:0]  rep_buf;
    logic                msb_buf;
    logic                idle_buf;
    logic [IDX_W-1:0]    bit_idx;
    logic [CNT_BIT-1:0]  period_cnt;
    logic [REP_BIT:0]    frame_cnt;
    logic                serial_q;

    logic                last_cycle;
    logic                last_bit;
    logic                frame_end;
    logic                final_frame;
    logic                one_shot;
    logic [REP_BIT:0]    frame_cnt_inc;
    logic [REP_BIT:0]    rep_eff;
    logic [IDX_W-1:0]    next_idx;
    logic [IDX_W-1:0]    next_sel;
    logic [IDX_W-1:0]    start_sel;

    // Physical bit position for a logical bit index, honouring the bit order
    function automatic logic [IDX_W-1:0] map_idx(input logic msb, input logic [IDX_W-1:0] idx);
        return msb ? (IDX_W'(DATA_BIT - 1) - idx) : idx;
    endfunction

    // Counter load value: a zero period behaves as one cycle
    function automatic logic [CNT_BIT-1:0] load_val(input logic sel,
                                                    input logic [CNT_BIT-1:0] lo,
                                                    input logic [CNT_BIT-1:0] hi);
        logic [CNT_BIT-1:0] p;
        p = sel ? hi : lo;
        return (p == '0) ? '0 : (p - CNT_BIT'(1));
    endfunction

    assign last_cycle    = (state == S_SHIFT) && (period_cnt == '0);
    assign last_bit      = (bit_idx == IDX_W'(DATA_BIT - 1));
    assign frame_end     = last_cycle && last_bit;
    assign frame_cnt_inc = frame_cnt + (REP_BIT+1)'(1);
    assign rep_eff       = (rep_buf == '0) ? (REP_BIT+1)'(1) : {1'b0, rep_buf};
    assign one_shot      = (mode_buf == 2'b00) || (mode_buf == 2'b11);
    assign final_frame   = one_shot || ((mode_buf == 2'b01) && (frame_cnt_inc == rep_eff));
    assign next_idx      = last_bit ? '0 : (bit_idx + IDX_W'(1));
    assign next_sel      = map_idx(msb_buf, next_idx);
    assign start_sel     = map_idx(i_msb_first, '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stop beats start; a start while shifting simply restarts in place
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (i_start && !i_stop) state_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (i_stop)                          state_next = S_IDLE;
                else if (i_start)                    state_next = S_SHIFT;
                else if (frame_end && final_frame)   state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_buf   <= '0;
            freq_buf   <= '0;
            low_buf    <= '0;
            high_buf   <= '0;
            mode_buf   <= '0;
            rep_buf    <= '0;
            msb_buf    <= 1'b0;
            idle_buf   <= 1'b0;
            bit_idx    <= '0;
            period_cnt <= '0;
            frame_cnt  <= '0;
            serial_q   <= 1'b0;
        end else if (i_stop) begin
            if (state == S_SHIFT) begin
                serial_q   <= idle_buf;
                bit_idx    <= '0;
                period_cnt <= '0;
                frame_cnt  <= '0;
            end
        end else if (i_start) begin
            data_buf   <= i_output_pattern;
            freq_buf   <= i_freq_pattern;
            low_buf    <= i_low_period;
            high_buf   <= i_high_period;
            mode_buf   <= i_mode;
            rep_buf    <= i_repeat;
            msb_buf    <= i_msb_first;
            idle_buf   <= i_idle_level;
            bit_idx    <= '0;
            frame_cnt  <= '0;
            serial_q   <= i_output_pattern[start_sel];
            period_cnt <= load_val(i_freq_pattern[start_sel], i_low_period, i_high_period);
        end else if (state == S_SHIFT) begin
            if (period_cnt != '0) begin
                period_cnt <= period_cnt - CNT_BIT'(1);
            end else if (frame_end && final_frame) begin
                serial_q  <= idle_buf;
                bit_idx   <= '0;
                frame_cnt <= '0;
            end else begin
                // Next bit (or first bit of the next frame) follows with no gap
                bit_idx    <= next_idx;
                serial_q   <= data_buf[next_sel];
                period_cnt <= load_val(freq_buf[next_sel], low_buf, high_buf);
                if (last_bit) frame_cnt <= frame_cnt_inc;
            end
        end
    end

    always_comb begin
        o_busy          = (state == S_SHIFT);
        o_bit_tick      = last_cycle && !i_start && !i_stop;
        o_done_tick     = o_bit_tick && last_bit;
        o_all_done_tick = o_done_tick && final_frame;
    end

    assign o_serial_out = serial_q;

endmodule

// File: tb/tb_serial_out_prog.sv
// Randomized and directed bench for serial_out_prog; expected waveforms come from a
// per-cycle queue built by expanding each frame's bits into their hold periods.
module tb_serial_out_prog;

    localparam int DB = 8;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic       i_stop;
    logic [1:0] i_mode;
    logic [7:0] i_repeat;
    logic       i_msb_first;
    logic       i_idle_level;
    logic [7:0] i_output_pattern;
    logic [7:0] i_freq_pattern;
    logic [7:0] i_low_period;
    logic [7:0] i_high_period;
    logic       o_serial_out;
    logic       o_busy;
    logic       o_bit_tick;
    logic       o_done_tick;
    logic       o_all_done_tick;

    serial_out_prog #(.DATA_BIT(DB), .CNT_BIT(8), .REP_BIT(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (i_start),
        .i_stop           (i_stop),
        .i_mode           (i_mode),
        .i_repeat         (i_repeat),
        .i_msb_first      (i_msb_first),
        .i_idle_level     (i_idle_level),
        .i_output_pattern (i_output_pattern),
        .i_freq_pattern   (i_freq_pattern),
        .i_low_period     (i_low_period),
        .i_high_period    (i_high_period),
        .o_serial_out     (o_serial_out),
        .o_busy           (o_busy),
        .o_bit_tick       (o_bit_tick),
        .o_done_tick      (o_done_tick),
        .o_all_done_tick  (o_all_done_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic s;
        logic bt;
        logic dt;
        logic adt;
    } exp_t;

    exp_t q[$];
    logic       m_idle;
    logic       m_cont;
    logic [7:0] m_pat, m_freq, m_lo, m_hi;
    logic       m_msb;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cnt_busy, cnt_bt, cnt_dt, cnt_adt;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // One frame expanded into per-cycle expectations
    task automatic push_frame(input logic [7:0] pat, input logic [7:0] freq, input logic msb,
                              input logic [7:0] lo, input logic [7:0] hi, input logic last_all);
        for (int i = 0; i < DB; i++) begin
            int k;
            int p;
            k = msb ? (DB - 1 - i) : i;
            p = freq[k] ? int'(hi) : int'(lo);
            if (p == 0) p = 1;
            for (int c = 1; c <= p; c++) begin
                exp_t e;
                e.s   = pat[k];
                e.bt  = (c == p);
                e.dt  = (c == p) && (i == DB - 1);
                e.adt = e.dt && last_all;
                q.push_back(e);
            end
        end
    endtask

    task automatic clearCounts();
        cnt_busy = 0; cnt_bt = 0; cnt_dt = 0; cnt_adt = 0;
    endtask

    // Drive one cycle of inputs, check outputs against the model, then advance the model
    task automatic applyStimulus(input logic start, input logic stop, input logic [1:0] mode,
                                 input logic [7:0] rep, input logic msb, input logic idle,
                                 input logic [7:0] pat, input logic [7:0] freq,
                                 input logic [7:0] lo, input logic [7:0] hi);
        exp_t e;
        exp_t tmp;
        logic eb;
        int nframes;
        @(negedge clk);
        i_start = start; i_stop = stop; i_mode = mode; i_repeat = rep;
        i_msb_first = msb; i_idle_level = idle; i_output_pattern = pat;
        i_freq_pattern = freq; i_low_period = lo; i_high_period = hi;
        #1;
        cyc++;
        if (q.size() > 0) begin
            e = q[0];
            eb = 1'b1;
        end else begin
            e.s = m_idle; e.bt = 1'b0; e.dt = 1'b0; e.adt = 1'b0;
            eb = 1'b0;
        end
        if (eb && (start || stop)) begin
            e.bt = 1'b0; e.dt = 1'b0; e.adt = 1'b0;
        end
        checkOutput("serial", 32'(o_serial_out), 32'(e.s));
        checkOutput("busy", 32'(o_busy), 32'(eb));
        checkOutput("bit_tick", 32'(o_bit_tick), 32'(e.bt));
        checkOutput("done_tick", 32'(o_done_tick), 32'(e.dt));
        checkOutput("all_done_tick", 32'(o_all_done_tick), 32'(e.adt));
        if (o_busy === 1'b1) cnt_busy++;
        if (o_bit_tick === 1'b1) cnt_bt++;
        if (o_done_tick === 1'b1) cnt_dt++;
        if (o_all_done_tick === 1'b1) cnt_adt++;

        if (stop) begin
            q.delete();
            m_cont = 1'b0;
        end else if (start) begin
            q.delete();
            m_idle = idle;
            m_cont = (mode == 2'b10);
            m_pat = pat; m_freq = freq; m_msb = msb; m_lo = lo; m_hi = hi;
            nframes = (mode == 2'b01) ? ((rep == 0) ? 1 : int'(rep)) : 1;
            for (int f = 0; f < nframes; f++)
                push_frame(pat, freq, msb, lo, hi, (mode != 2'b10) && (f == nframes - 1));
        end else if (q.size() > 0) begin
            tmp = q.pop_front();
            if (q.size() == 0 && m_cont) push_frame(m_pat, m_freq, m_msb, m_lo, m_hi, 1'b0);
        end
    endtask

    // Idle cycles with garbage on the configuration inputs, which must be ignored
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 2'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                          8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic midFrameReset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_serial", 32'(o_serial_out), 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_bit_tick", 32'(o_bit_tick), 32'd0);
        checkOutput("rst_done_tick", 32'(o_done_tick), 32'd0);
        checkOutput("rst_all_done", 32'(o_all_done_tick), 32'd0);
        q.delete();
        m_cont = 1'b0;
        m_idle = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        i_start = 0; i_stop = 0; i_mode = 0; i_repeat = 0; i_msb_first = 0;
        i_idle_level = 0; i_output_pattern = 0; i_freq_pattern = 0;
        i_low_period = 0; i_high_period = 0;
        m_idle = 0; m_cont = 0; m_pat = 0; m_freq = 0; m_msb = 0; m_lo = 0; m_hi = 0;
        clearCounts();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_serial", 32'(o_serial_out), 32'd0);
        checkOutput("reset_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(3);

        $display("[TB] one-shot LSB first");
        clearCounts();
        applyStimulus(1, 0, 2'b00, 8'd0, 0, 0, 8'hA5, 8'h0F, 8'd4, 8'd2);
        idleCycles(30);
        checkOutput("t1_busy_cycles", 32'(cnt_busy), 32'd24);
        checkOutput("t1_bit_ticks", 32'(cnt_bt), 32'd8);
        checkOutput("t1_done_ticks", 32'(cnt_dt), 32'd1);
        checkOutput("t1_all_done", 32'(cnt_adt), 32'd1);

        $display("[TB] one-shot MSB first, idle high");
        applyStimulus(1, 0, 2'b11, 8'd0, 1, 1, 8'hA5, 8'h0F, 8'd4, 8'd2);
        idleCycles(28);
        checkOutput("t2_idle_level", 32'(o_serial_out), 32'd1);

        $display("[TB] repeat-N gapless");
        clearCounts();
        applyStimulus(1, 0, 2'b01, 8'd3, 0, 0, 8'h3C, 8'h55, 8'd1, 8'd1);
        idleCycles(30);
        checkOutput("t3_busy_cycles", 32'(cnt_busy), 32'd24);
        checkOutput("t3_done_ticks", 32'(cnt_dt), 32'd3);
        checkOutput("t3_all_done", 32'(cnt_adt), 32'd1);

        $display("[TB] continuous with stop");
        clearCounts();
        applyStimulus(1, 0, 2'b10, 8'd0, 0, 1, 8'h96, 8'h0F, 8'd0, 8'd3);
        idleCycles(12);
        applyStimulus(0, 1, 2'b00, 8'd0, 0, 0, 8'h00, 8'h00, 8'd0, 8'd0);
        idleCycles(5);
        checkOutput("t4_busy_cycles", 32'(cnt_busy), 32'd13);
        checkOutput("t4_done_ticks", 32'(cnt_dt), 32'd0);
        checkOutput("t4_stop_idle", 32'(o_serial_out), 32'd1);

        $display("[TB] restart and start+stop");
        applyStimulus(1, 0, 2'b00, 8'd0, 0, 0, 8'h00, 8'h00, 8'd3, 8'd3);
        idleCycles(4);
        applyStimulus(1, 0, 2'b00, 8'd0, 0, 0, 8'hFF, 8'hAA, 8'd2, 8'd1);
        idleCycles(20);
        applyStimulus(1, 0, 2'b10, 8'd0, 0, 1, 8'h5A, 8'h00, 8'd2, 8'd2);
        idleCycles(3);
        applyStimulus(1, 1, 2'b00, 8'd0, 0, 0, 8'h00, 8'h00, 8'd1, 8'd1);
        idleCycles(2);
        checkOutput("t5_old_idle", 32'(o_serial_out), 32'd1);
        applyStimulus(1, 1, 2'b10, 8'd0, 0, 0, 8'hFF, 8'hFF, 8'd1, 8'd1);
        idleCycles(2);
        checkOutput("t5_idle_start_stop", 32'(o_busy), 32'd0);

        $display("[TB] reset mid-frame");
        applyStimulus(1, 0, 2'b10, 8'd0, 0, 1, 8'hFF, 8'h00, 8'd5, 8'd5);
        idleCycles(6);
        midFrameReset();
        idleCycles(2);
        applyStimulus(1, 0, 2'b00, 8'd0, 1, 0, 8'hC3, 8'hF0, 8'd2, 8'd0);
        idleCycles(20);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 1500; n++) begin
            logic st, sp;
            st = ($urandom_range(0, 19) == 0);
            sp = ($urandom_range(0, 59) == 0);
            applyStimulus(st, sp, 2'($urandom), 8'($urandom_range(0, 3)), 1'($urandom),
                          1'($urandom), 8'($urandom), 8'($urandom),
                          8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
        end
        applyStimulus(0, 1, 2'b00, 8'd0, 0, 0, 8'h00, 8'h00, 8'd0, 8'd0);
        idleCycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
